// File: rtl/iob_eth_pkg.sv
// Shared definitions for the Ethernet RX frame-store controller:
// FSM state encodings, slot count and default slot address width.
package iob_eth_pkg;

    localparam int NSLOTS         = 2;
    localparam int DEF_BUF_ADDR_W = 11;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DROP = 2'd2
    } rx_state_t;

endpackage

// File: rtl/iob_eth_sat_cnt.sv
// Saturating event counter with synchronous clear (clear beats increment).
module iob_eth_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !(&r_cnt)) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/iob_eth_rx_buf_ctrl.sv
// Two-slot ping-pong RX frame store sequencer between RX engine and CPU.
// Optional statistics counters enabled by defining IOB_ETH_RX_STATS_EN.
module iob_eth_rx_buf_ctrl
    import iob_eth_pkg::*;
#(
    parameter int BUF_ADDR_W = DEF_BUF_ADDR_W,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_sof,
    input  logic                  rx_wr,
    input  logic [7:0]            rx_data,
    input  logic                  rx_eof_ok,
    input  logic                  rx_eof_err,
    output logic                  buf_wr_en,
    output logic [BUF_ADDR_W:0]   buf_wr_addr,
    output logic [7:0]            buf_wr_data,
    input  logic [BUF_ADDR_W-1:0] cpu_rd_addr,
    output logic [BUF_ADDR_W:0]   buf_rd_addr,
    output logic                  frame_avail,
    output logic [BUF_ADDR_W:0]   frame_len,
    input  logic                  frame_release,
    output logic                  rx_busy,
    output logic                  rx_overflow
`ifdef IOB_ETH_RX_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [CNT_W-1:0]      stat_ok,
    output logic [CNT_W-1:0]      stat_crc_err,
    output logic [CNT_W-1:0]      stat_drop
`endif
);

    localparam logic [BUF_ADDR_W:0] ONE = {{BUF_ADDR_W{1'b0}}, 1'b1};

    rx_state_t             r_state;
    rx_state_t             w_state_nxt;
    logic [BUF_ADDR_W:0]   r_off;
    logic [BUF_ADDR_W:0]   w_off_nxt;
    logic [NSLOTS-1:0]     r_full;
    logic [NSLOTS-1:0]     w_full_nxt;
    logic [BUF_ADDR_W:0]   r_len0;
    logic [BUF_ADDR_W:0]   r_len1;
    logic                  r_wr_slot;
    logic                  r_rd_slot;
    logic                  r_ovf;

    logic                  w_recv;
    logic                  w_free;
    logic                  w_exhausted;
    logic                  w_slot_end;
    logic                  w_wr;
    logic                  w_commit;
    logic                  w_crc_err;
    logic                  w_drop_entry;
    logic                  w_ovf_drop;
    logic                  w_release;
    logic [BUF_ADDR_W:0]   w_len_new;

    assign w_recv      = (r_state == RX_RECV) && !rx_sof;
    assign w_free      = !r_full[r_wr_slot];
    assign w_exhausted = r_off[BUF_ADDR_W];
    // A byte arriving with the slot already full ends the frame as a drop
    assign w_slot_end  = w_recv && rx_wr && w_exhausted;
    assign w_wr        = w_recv && rx_wr && !w_exhausted;
    assign w_commit    = w_recv && rx_eof_ok && !w_slot_end;
    assign w_crc_err   = w_recv && rx_eof_err && !w_slot_end;
    assign w_ovf_drop  = rx_sof && !w_free;
    assign w_drop_entry = w_ovf_drop || w_slot_end;
    assign w_release   = frame_release && r_full[r_rd_slot];
    assign w_len_new   = r_off + (w_wr ? ONE : '0);

    always_comb begin
        w_state_nxt = r_state;
        w_off_nxt   = r_off;
        if (rx_sof) begin
            w_state_nxt = w_free ? RX_RECV : RX_DROP;
            w_off_nxt   = '0;
        end else begin
            unique case (r_state)
                RX_RECV: begin
                    if (rx_wr && w_exhausted) begin
                        w_state_nxt = RX_DROP;
                    end else begin
                        if (rx_wr) begin
                            w_off_nxt = r_off + ONE;
                        end
                        if (rx_eof_ok || rx_eof_err) begin
                            w_state_nxt = RX_IDLE;
                        end
                    end
                end
                RX_DROP: begin
                    if (rx_eof_ok || rx_eof_err) begin
                        w_state_nxt = RX_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_comb begin
        w_full_nxt = r_full;
        if (w_commit) begin
            w_full_nxt[r_wr_slot] = 1'b1;
        end
        if (w_release) begin
            w_full_nxt[r_rd_slot] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RX_IDLE;
            r_off   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_off   <= w_off_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= '0;
            r_len0    <= '0;
            r_len1    <= '0;
            r_wr_slot <= 1'b0;
            r_rd_slot <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_commit) begin
                if (r_wr_slot) begin
                    r_len1 <= w_len_new;
                end else begin
                    r_len0 <= w_len_new;
                end
                r_wr_slot <= ~r_wr_slot;
            end
            if (w_release) begin
                r_rd_slot <= ~r_rd_slot;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_drop) begin
            r_ovf <= 1'b1;
        end else if (w_release) begin
            r_ovf <= 1'b0;
        end
    end

    assign buf_wr_en   = w_wr;
    assign buf_wr_addr = {r_wr_slot, r_off[BUF_ADDR_W-1:0]};
    assign buf_wr_data = w_wr ? rx_data : 8'h00;
    assign buf_rd_addr = {r_rd_slot, cpu_rd_addr};
    assign frame_avail = r_full[r_rd_slot];
    assign frame_len   = r_rd_slot ? r_len1 : r_len0;
    assign rx_busy     = (r_state == RX_RECV);
    assign rx_overflow = r_ovf;

`ifdef IOB_ETH_RX_STATS_EN
    iob_eth_sat_cnt #(.W(CNT_W)) u_cnt_ok (
        .clk   (clk),
        .rst   (rst),
        .i_clr (stat_clr),
        .i_en  (w_commit),
        .o_cnt (stat_ok)
    );

    iob_eth_sat_cnt #(.W(CNT_W)) u_cnt_err (
        .clk   (clk),
        .rst   (rst),
        .i_clr (stat_clr),
        .i_en  (w_crc_err),
        .o_cnt (stat_crc_err)
    );

    iob_eth_sat_cnt #(.W(CNT_W)) u_cnt_drop (
        .clk   (clk),
        .rst   (rst),
        .i_clr (stat_clr),
        .i_en  (w_drop_entry),
        .o_cnt (stat_drop)
    );
`else
    logic w_unused_stats;
    assign w_unused_stats = w_crc_err ^ w_drop_entry ^ (CNT_W > 0);
`endif

endmodule

// File: tb/tb_iob_eth_rx_buf_ctrl.sv
// Randomized bench for iob_eth_rx_buf_ctrl against a frame-queue model.
// Stats checks are compiled in when IOB_ETH_RX_STATS_EN is defined.
module tb_iob_eth_rx_buf_ctrl;

    localparam int AW   = 11;
    localparam int SLOT = 1 << AW;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_sof, rx_wr, rx_eof_ok, rx_eof_err;
    logic [7:0]    rx_data;
    logic          buf_wr_en;
    logic [AW:0]   buf_wr_addr;
    logic [7:0]    buf_wr_data;
    logic [AW-1:0] cpu_rd_addr;
    logic [AW:0]   buf_rd_addr;
    logic          frame_avail;
    logic [AW:0]   frame_len;
    logic          frame_release;
    logic          rx_busy;
    logic          rx_overflow;
`ifdef IOB_ETH_RX_STATS_EN
    logic          stat_clr;
    logic [CW-1:0] stat_ok, stat_crc_err, stat_drop;
    int            m_ok, m_err, m_drop;
`endif

    iob_eth_rx_buf_ctrl #(
        .BUF_ADDR_W (AW)
`ifdef IOB_ETH_RX_STATS_EN
        , .CNT_W    (CW)
`endif
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_sof        (rx_sof),
        .rx_wr         (rx_wr),
        .rx_data       (rx_data),
        .rx_eof_ok     (rx_eof_ok),
        .rx_eof_err    (rx_eof_err),
        .buf_wr_en     (buf_wr_en),
        .buf_wr_addr   (buf_wr_addr),
        .buf_wr_data   (buf_wr_data),
        .cpu_rd_addr   (cpu_rd_addr),
        .buf_rd_addr   (buf_rd_addr),
        .frame_avail   (frame_avail),
        .frame_len     (frame_len),
        .frame_release (frame_release),
        .rx_busy       (rx_busy),
        .rx_overflow   (rx_overflow)
`ifdef IOB_ETH_RX_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_ok       (stat_ok),
        .stat_crc_err  (stat_crc_err),
        .stat_drop     (stat_drop)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int slot;
        int len;
    } frm_t;

    frm_t q[$];
    int   m_wr_slot;
    int   m_rd_slot;
    bit   m_ovf;
    bit   clr_on_eof;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        q.delete();
        m_wr_slot = 0;
        m_rd_slot = 0;
        m_ovf     = 1'b0;
`ifdef IOB_ETH_RX_STATS_EN
        m_ok = 0; m_err = 0; m_drop = 0;
`endif
    endtask

    task automatic check_state(input string tag);
        cpu_rd_addr = AW'($urandom_range(0, SLOT - 1));
        @(negedge clk);
        chk({tag, ".avail"}, frame_avail, (q.size() > 0));
        if (q.size() > 0) chk({tag, ".len"}, frame_len, q[0].len);
        chk({tag, ".ovf"}, rx_overflow, m_ovf);
        chk({tag, ".busy"}, rx_busy, 0);
        chk({tag, ".rd_addr"}, buf_rd_addr, m_rd_slot * SLOT + cpu_rd_addr);
`ifdef IOB_ETH_RX_STATS_EN
        chk({tag, ".st_ok"}, stat_ok, m_ok);
        chk({tag, ".st_err"}, stat_crc_err, m_err);
        chk({tag, ".st_drop"}, stat_drop, m_drop);
`endif
    endtask

    task automatic send_frame(input int len, input bit ok);
        bit acc;
        bit w;
        acc = (q.size() < 2);
        rx_sof = 1'b1;
        step();
        rx_sof = 1'b0;
        if (!acc) begin
            m_ovf = 1'b1;
`ifdef IOB_ETH_RX_STATS_EN
            m_drop = sat(m_drop);
`endif
        end
        for (int i = 0; i < len; i++) begin
            rx_wr   = 1'b1;
            rx_data = 8'($urandom_range(0, 255));
            @(negedge clk);
            w = acc && (i < SLOT);
            chk("wr_en", buf_wr_en, w);
            chk("wr_busy", rx_busy, acc && (i <= SLOT));
            if (w) begin
                chk("wr_addr", buf_wr_addr, m_wr_slot * SLOT + i);
                chk("wr_data", buf_wr_data, rx_data);
            end
            step();
        end
        rx_wr = 1'b0;
`ifdef IOB_ETH_RX_STATS_EN
        if (acc && len > SLOT) m_drop = sat(m_drop);
        stat_clr = clr_on_eof;
`endif
        if (ok) rx_eof_ok = 1'b1;
        else rx_eof_err = 1'b1;
        step();
        rx_eof_ok  = 1'b0;
        rx_eof_err = 1'b0;
        if (acc && len <= SLOT) begin
            if (ok) begin
                q.push_back('{slot: m_wr_slot, len: len});
                m_wr_slot ^= 1;
`ifdef IOB_ETH_RX_STATS_EN
                m_ok = sat(m_ok);
`endif
            end else begin
`ifdef IOB_ETH_RX_STATS_EN
                m_err = sat(m_err);
`endif
            end
        end
`ifdef IOB_ETH_RX_STATS_EN
        stat_clr = 1'b0;
        if (clr_on_eof) begin
            m_ok = 0; m_err = 0; m_drop = 0;
        end
`endif
        check_state(ok ? "eof_ok" : "eof_err");
    endtask

    task automatic release_frame();
        frame_release = 1'b1;
        step();
        frame_release = 1'b0;
        if (q.size() > 0) begin
            void'(q.pop_front());
            m_rd_slot ^= 1;
            m_ovf = 1'b0;
        end
        check_state("release");
    endtask

    task automatic reset_mid_frame();
        rx_sof = 1'b1;
        step();
        rx_sof = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rx_wr   = 1'b1;
            rx_data = 8'hA5;
            step();
        end
        rst = 1'b1;
        #1;
        chk("rst.wr_en", buf_wr_en, 0);
        chk("rst.wr_addr", buf_wr_addr, 0);
        chk("rst.wr_data", buf_wr_data, 0);
        chk("rst.avail", frame_avail, 0);
        chk("rst.len", frame_len, 0);
        chk("rst.busy", rx_busy, 0);
        chk("rst.ovf", rx_overflow, 0);
        rx_wr = 1'b0;
        step();
        rst = 1'b0;
        model_reset();
        check_state("post_rst");
    endtask

    initial begin
        rst           = 1'b1;
        rx_sof        = 1'b0;
        rx_wr         = 1'b0;
        rx_data       = 8'h00;
        rx_eof_ok     = 1'b0;
        rx_eof_err    = 1'b0;
        cpu_rd_addr   = '0;
        frame_release = 1'b0;
        clr_on_eof    = 1'b0;
`ifdef IOB_ETH_RX_STATS_EN
        stat_clr      = 1'b0;
`endif
        model_reset();
        step();
        @(negedge clk);
        chk("reset.wr_en", buf_wr_en, 0);
        chk("reset.wr_addr", buf_wr_addr, 0);
        chk("reset.rd_addr", buf_rd_addr, 0);
        chk("reset.avail", frame_avail, 0);
        chk("reset.len", frame_len, 0);
        chk("reset.busy", rx_busy, 0);
        chk("reset.ovf", rx_overflow, 0);
        step();
        rst = 1'b0;
        check_state("idle");

        send_frame(64, 1'b1);
        release_frame();

        send_frame(60, 1'b1);
        send_frame(100, 1'b1);
        send_frame(40, 1'b1);
        release_frame();
        release_frame();
        release_frame();

        send_frame(30, 1'b0);
        send_frame(50, 1'b1);
        release_frame();

        send_frame(SLOT + 1, 1'b1);
        send_frame(SLOT, 1'b1);
        release_frame();

        send_frame(20, 1'b1);
        reset_mid_frame();
        send_frame(12, 1'b1);
        release_frame();

        for (int k = 0; k < 4; k++) begin
            send_frame($urandom_range(1, 40), 1'b1);
            release_frame();
        end
`ifdef IOB_ETH_RX_STATS_EN
        clr_on_eof = 1'b1;
        send_frame(8, 1'b1);
        clr_on_eof = 1'b0;
        release_frame();
`endif

        for (int k = 0; k < 40; k++) begin
            send_frame($urandom_range(1, 80), ($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 1) == 1) release_frame();
            if ($urandom_range(0, 5) == 0) release_frame();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
